spi_ram_master: RTL and testbench
=================================

SPI_RAM_MASTER -- requirements
Module: spi_ram_master

Interface
REQ-001 Parameter: ADDR_WIDTH, default 8, RAM address width and SPI payload width.
REQ-002 Parameter: GAP_CYCLES, default 1, minimum ss_n-high cycles between frames (legal range 1..15).
REQ-003 Port: clk  in  1  single system clock, shared with the SPI slave/RAM wrapper.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: req_valid  in  1  host request strobe.
REQ-006 Port: req_ready  out  1  high while idle and able to accept a request.
REQ-007 Port: req_rd  in  1  1 = read, 0 = write.
REQ-008 Port: req_addr  in  ADDR_WIDTH  target RAM address.
REQ-009 Port: req_wdata  in  8  write data; ignored for reads.
REQ-010 Port: rsp_valid  out  1  one-cycle pulse when a read completes.
REQ-011 Port: rsp_data  out  8  read data; held until the next read completes.
REQ-012 Port: busy  out  1  high from request acceptance through the end of the final gap.
REQ-013 Port: ss_n  out  1  slave select, active low.
REQ-014 Port: mosi  out  1  serial data to the slave.
REQ-015 Port: miso  in  1  serial data from the slave.

Function
REQ-016 A request is accepted on a cycle with req_valid && req_ready; req_rd, req_addr and req_wdata are latched on that cycle.
REQ-017 A write is sequenced as frame A = {2'b00, addr}, then frame B = {2'b01, wdata}.
REQ-018 A read is sequenced as frame A = {2'b10, addr}, then frame B = {2'b11, 8'h00}, with receive.
REQ-019 FSM states: IDLE, START, SHIFT, TURN, RECV, GAP.
REQ-020 IDLE->START on acceptance; ss_n goes low in START; mosi = 0 in START (slave command-check cycle).
REQ-021 SHIFT lasts exactly 10 cycles and drives the frame MSB first, one bit per clk.
REQ-022 After SHIFT, frame A and write frame B go to GAP.
REQ-023 After SHIFT, read frame B goes to TURN for 1 cycle, then RECV for 8 cycles.
REQ-024 In RECV, miso is sampled each cycle MSB first into a shift register.
REQ-025 ss_n is high in IDLE and GAP and low in START, SHIFT, TURN and RECV.
REQ-026 GAP lasts GAP_CYCLES cycles; it goes to START for frame B, otherwise to IDLE.
REQ-027 Write latency: acceptance to IDLE is 2*(1+10)+2*GAP_CYCLES cycles (24 at default).
REQ-028 Read latency: acceptance to IDLE is 11+GAP_CYCLES+20+GAP_CYCLES cycles (33 at default).
REQ-029 rsp_valid pulses in the first GAP cycle after RECV; rsp_data updates on the same cycle.
REQ-030 req_ready = (state == IDLE); busy = !req_ready.
REQ-031 A req_valid arriving while busy is not accepted; the host holds it until req_ready.
REQ-032 A request may be accepted on the same cycle the FSM returns to IDLE (back-to-back); no extra idle cycle is inserted.
REQ-033 mosi = 0 whenever ss_n is high.

Reset
REQ-034 On reset: state = IDLE, ss_n = 1, mosi = 0, rsp_valid = 0, rsp_data = 8'h00, busy = 0, req_ready = 1, bit counters = 0.
REQ-035 Reset asserted mid-frame aborts within the same cycle edge; no rsp_valid is produced for the aborted request.

Structure
REQ-036 A shared package holds command codes (CMD_WR_ADDR = 2'b00, CMD_WR_DATA = 2'b01, CMD_RD_ADDR = 2'b10, CMD_RD_DATA = 2'b11), the state encoding, FRAME_BITS = 10 and RX_BITS = 8.
REQ-037 One sub-module, spi_frame_shifter, holds the 10-bit TX shift register, 8-bit RX shift register and bit counter; the FSM lives in spi_ram_master.

Verification
REQ-038 Write addr 8'h3C, data 8'hA5 -> mosi stream 0,00_00111100, then 0,01_10100101; ss_n low 11 cycles per frame; busy for 24 cycles.
REQ-039 Write then read addr 8'h3C via the SPI slave/RAM wrapper -> rsp_valid single pulse with rsp_data = 8'hA5, 33 cycles after read acceptance.
REQ-040 Back-to-back reads of 8'h00 and 8'hFF with req_valid held high -> second accepted on the cycle req_ready returns; two rsp_valid pulses, each with the correct data.
REQ-041 req_valid pulsed while busy -> no acceptance; latched addr/data unchanged; frame bits unaffected.
REQ-042 Reset asserted during read RECV bit 4 -> next cycle ss_n = 1, state IDLE, no rsp_valid, rsp_data = 8'h00.
REQ-043 GAP_CYCLES = 3, write -> ss_n high exactly 3 cycles between frames; total busy of 28 cycles.

Source files
------------

// File: rtl/spi_ram_master_pkg.sv
// Shared definitions for the SPI RAM master: command codes, FSM encoding and
// the frame geometry used by both the FSM and the frame shifter.
package spi_ram_master_pkg;

    localparam int FRAME_BITS = 10;
    localparam int RX_BITS    = 8;
    localparam int CNT_WIDTH  = 4;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        START,
        SHIFT,
        TURN,
        RECV,
        GAP
    } state_t;

endpackage

// File: rtl/spi_frame_shifter.sv
// Datapath for one SPI frame: 10-bit transmit shifter with registered mosi,
// 8-bit receive shifter and the shared bit counter.
module spi_frame_shifter
    import spi_ram_master_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [FRAME_BITS-1:0] frame,
    input  logic                  shift_en,
    input  logic                  rx_en,
    input  logic                  miso,
    output logic                  mosi,
    output logic                  shift_last,
    output logic                  rx_last,
    output logic [RX_BITS-1:0]    rx_next
);

    logic [FRAME_BITS-1:0] tx_q, tx_d;
    logic [RX_BITS-1:0]    rx_q, rx_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  mosi_q, mosi_d;

    assign shift_last = (cnt_q == CNT_WIDTH'(FRAME_BITS - 1));
    assign rx_last    = (cnt_q == CNT_WIDTH'(RX_BITS - 1));
    assign rx_next    = RX_BITS'({rx_q, miso});
    assign mosi       = mosi_q;

    // mosi is one register ahead of tx_q: loading puts the MSB on the wire for
    // the first SHIFT cycle, and the last SHIFT cycle returns the line to 0.
    always_comb begin
        tx_d   = tx_q;
        rx_d   = rx_q;
        cnt_d  = '0;
        mosi_d = 1'b0;
        if (load) begin
            tx_d   = {frame[FRAME_BITS-2:0], 1'b0};
            mosi_d = frame[FRAME_BITS-1];
        end else if (shift_en) begin
            if (!shift_last) begin
                mosi_d = tx_q[FRAME_BITS-1];
                tx_d   = {tx_q[FRAME_BITS-2:0], 1'b0};
                cnt_d  = cnt_q + CNT_WIDTH'(1);
            end
        end else if (rx_en) begin
            rx_d = rx_next;
            if (!rx_last) begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_q   <= '0;
            rx_q   <= '0;
            cnt_q  <= '0;
            mosi_q <= 1'b0;
        end else begin
            tx_q   <= tx_d;
            rx_q   <= rx_d;
            cnt_q  <= cnt_d;
            mosi_q <= mosi_d;
        end
    end

endmodule

// File: rtl/spi_ram_master.sv
// Host-side SPI master: each read/write request becomes an address frame and a
// data frame to an SPI RAM slave, separated by a programmable ss_n-high gap.
module spi_ram_master
    import spi_ram_master_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_rd,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [7:0]            req_wdata,
    output logic                  rsp_valid,
    output logic [7:0]            rsp_data,
    output logic                  busy,
    output logic                  ss_n,
    output logic                  mosi,
    input  logic                  miso
);

    state_t                state_q, state_d;
    logic                  rd_q, rd_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            wdata_q, wdata_d;
    logic                  phase_b_q, phase_b_d;
    logic [3:0]            gap_cnt_q, gap_cnt_d;
    logic                  ss_n_q, ss_n_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [7:0]            rsp_data_q, rsp_data_d;

    logic [1:0]            cmd;
    logic [7:0]            payload;
    logic                  shift_last;
    logic                  rx_last;
    logic [RX_BITS-1:0]    rx_next;

    // The payload is 8 bits wide; the address is fitted to it.
    always_comb begin
        if (!phase_b_q) begin
            cmd     = rd_q ? CMD_RD_ADDR : CMD_WR_ADDR;
            payload = 8'(addr_q);
        end else if (rd_q) begin
            cmd     = CMD_RD_DATA;
            payload = 8'h00;
        end else begin
            cmd     = CMD_WR_DATA;
            payload = wdata_q;
        end
    end

    spi_frame_shifter u_shifter (
        .clk        (clk),
        .reset      (reset),
        .load       (state_q == START),
        .frame      ({cmd, payload}),
        .shift_en   (state_q == SHIFT),
        .rx_en      (state_q == RECV),
        .miso       (miso),
        .mosi       (mosi),
        .shift_last (shift_last),
        .rx_last    (rx_last),
        .rx_next    (rx_next)
    );

    // phase_b_q selects frame B; only a read's frame B turns around to receive.
    always_comb begin
        state_d     = state_q;
        rd_d        = rd_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        phase_b_d   = phase_b_q;
        gap_cnt_d   = gap_cnt_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d   = START;
                    rd_d      = req_rd;
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    phase_b_d = 1'b0;
                end
            end
            START: state_d = SHIFT;
            SHIFT: begin
                if (shift_last) begin
                    if (phase_b_q && rd_q) begin
                        state_d = TURN;
                    end else begin
                        state_d   = GAP;
                        gap_cnt_d = '0;
                    end
                end
            end
            TURN: state_d = RECV;
            RECV: begin
                if (rx_last) begin
                    state_d     = GAP;
                    gap_cnt_d   = '0;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = rx_next;
                end
            end
            GAP: begin
                if (gap_cnt_q == 4'(GAP_CYCLES - 1)) begin
                    if (phase_b_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = START;
                        phase_b_d = 1'b1;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        ss_n_d = !(state_d inside {START, SHIFT, TURN, RECV});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rd_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            phase_b_q   <= 1'b0;
            gap_cnt_q   <= '0;
            ss_n_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            phase_b_q   <= phase_b_d;
            gap_cnt_q   <= gap_cnt_d;
            ss_n_q      <= ss_n_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = !req_ready;
    assign ss_n      = ss_n_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_spi_ram_master.sv
// Scoreboard bench for spi_ram_master with a behavioural SPI RAM slave; a
// second instance with GAP_CYCLES = 3 checks the longer inter-frame gap.
module tb_spi_ram_master;

    localparam int WR_LAT = 24;
    localparam int RD_LAT = 33;

    typedef struct {
        logic [9:0] bits;
        int         len;
    } frame_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_rd = 1'b0;
    logic [7:0] req_addr = 8'h00;
    logic [7:0] req_wdata = 8'h00;
    logic       miso = 1'b0;
    logic       req_ready, rsp_valid, busy, ss_n, mosi;
    logic [7:0] rsp_data;

    logic       req_valid3 = 1'b0;
    logic       req_ready3, rsp_valid3, busy3, ss_n3, mosi3;
    logic [7:0] rsp_data3;

    int total = 0;
    int bad = 0;

    frame_t     frame_q[$];
    logic [7:0] rsp_q[$];
    int         lat_q[$];
    int         accept_q[$];
    int         rd_accept_q[$];

    logic [7:0] mem [256];
    logic [9:0] frm = '0;
    logic [7:0] s_addr = '0;
    logic       start_mosi = 1'b0;
    int         pos = 0;
    int         cyc = 0;
    logic       idle_bad = 1'b0;
    logic       busy_bad = 1'b0;
    logic       rsp3_seen = 1'b0;

    always #5 clk = ~clk;

    spi_ram_master #(.ADDR_WIDTH(8), .GAP_CYCLES(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rd    (req_rd),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .ss_n      (ss_n),
        .mosi      (mosi),
        .miso      (miso)
    );

    spi_ram_master #(.ADDR_WIDTH(8), .GAP_CYCLES(3)) dut3 (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid3),
        .req_ready (req_ready3),
        .req_rd    (req_rd),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid3),
        .rsp_data  (rsp_data3),
        .busy      (busy3),
        .ss_n      (ss_n3),
        .mosi      (mosi3),
        .miso      (1'b0)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
        end
    endtask

    task automatic reportFail(input string name, input logic [31:0] actual);
        total++;
        bad++;
        $display("[TB] FAIL %s: got %0h, want none", name, actual);
    endtask

    // Behavioural SPI RAM slave: decodes frames, serves read data on miso
    // during the receive window and scores every completed frame.
    always @(negedge clk) begin
        if (reset) begin
            pos  = 0;
            miso = 1'b0;
        end else if (!ss_n) begin
            if (pos == 0) start_mosi = mosi;
            else if (pos <= 10) frm[10-pos] = mosi;
            if (pos >= 12 && pos <= 19) miso = mem[s_addr][19-pos];
            else miso = 1'b0;
            pos++;
        end else begin
            miso = 1'b0;
            if (mosi) idle_bad = 1'b1;
            if (pos > 0) begin
                if (frame_q.size() == 0) begin
                    reportFail("frame_unexpected", {22'd0, frm});
                end else begin
                    frame_t f;
                    f = frame_q.pop_front();
                    checkOutput("frame_bits", {22'd0, frm}, {22'd0, f.bits});
                    checkOutput("frame_len", pos, f.len);
                    checkOutput("start_mosi", {31'd0, start_mosi}, 32'd0);
                end
                case (frm[9:8])
                    2'b00, 2'b10: s_addr = frm[7:0];
                    2'b01:        mem[s_addr] = frm[7:0];
                    default:      ;
                endcase
                pos = 0;
            end
        end
    end

    // Monitor: pairs acceptances with expected busy length and responses.
    always @(negedge clk) begin
        int a;
        cyc++;
        if (reset) begin
            accept_q.delete();
            rd_accept_q.delete();
        end else begin
            if (busy !== !req_ready) busy_bad = 1'b1;
            if (rsp_valid3) rsp3_seen = 1'b1;
            if (ss_n3 && mosi3) idle_bad = 1'b1;
            if (req_ready && accept_q.size() > 0) begin
                a = accept_q.pop_front();
                if (lat_q.size() == 0) reportFail("latency_unexpected", cyc - a - 1);
                else checkOutput("busy_cycles", cyc - a - 1, lat_q.pop_front());
            end
            if (req_valid && req_ready) begin
                accept_q.push_back(cyc);
                if (req_rd) rd_accept_q.push_back(cyc);
            end
            if (rsp_valid) begin
                if (rsp_q.size() == 0 || rd_accept_q.size() == 0) begin
                    reportFail("rsp_unexpected", {24'd0, rsp_data});
                end else begin
                    checkOutput("rsp_data", {24'd0, rsp_data}, {24'd0, rsp_q.pop_front()});
                    a = rd_accept_q.pop_front();
                    checkOutput("rsp_latency", cyc - a, RD_LAT);
                end
            end
        end
    end

    task automatic waitAccept();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 200);
        if (!req_ready) reportFail("accept_timeout", n);
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rd, input logic [7:0] addr,
                                 input logic [7:0] wdata, input logic [7:0] exp_rdata,
                                 input logic hold);
        frame_t f;
        req_rd    = rd;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        f.bits = {rd, 1'b0, addr};
        f.len  = 11;
        frame_q.push_back(f);
        f.bits = rd ? {2'b11, 8'h00} : {2'b01, wdata};
        f.len  = rd ? 20 : 11;
        frame_q.push_back(f);
        lat_q.push_back(rd ? RD_LAT : WR_LAT);
        if (rd) rsp_q.push_back(exp_rdata);
        waitAccept();
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(req_ready && frame_q.size() == 0 && rsp_q.size() == 0) && n < 300);
        if (n >= 300) reportFail("idle_timeout", n);
        @(posedge clk);
        #1;
    endtask

    task automatic gapThreeTest();
        int n = 0;
        int busy_n = 0;
        int gap_n = 0;
        int phase = 0;
        req_rd     = 1'b0;
        req_addr   = 8'h3C;
        req_wdata  = 8'hA5;
        req_valid3 = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready3 && n < 50);
        @(posedge clk);
        #1;
        req_valid3 = 1'b0;
        n = 0;
        forever begin
            @(negedge clk);
            if (!busy3 || n > 100) break;
            busy_n++;
            n++;
            case (phase)
                0: if (ss_n3) begin phase = 1; gap_n++; end
                1: if (ss_n3) gap_n++; else phase = 2;
                2: if (ss_n3) phase = 3;
                default: ;
            endcase
        end
        checkOutput("gap3_busy", busy_n, 28);
        checkOutput("gap3_ss_high", gap_n, 3);
        checkOutput("gap3_rsp_valid", {31'd0, rsp3_seen}, 32'd0);
        checkOutput("gap3_rsp_data", {24'd0, rsp_data3}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic abortRead(input logic [7:0] addr);
        frame_t f;
        req_rd    = 1'b1;
        req_addr  = addr;
        req_wdata = 8'h00;
        req_valid = 1'b1;
        f.bits = {2'b10, addr};
        f.len  = 11;
        frame_q.push_back(f);
        waitAccept();
        req_valid = 1'b0;
        // 28 edges after acceptance puts us in the fifth receive cycle.
        repeat (28) @(posedge clk);
        #1;
        checkOutput("abort_pre_ss_n", {31'd0, ss_n}, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_ss_n", {31'd0, ss_n}, 32'd1);
        checkOutput("abort_mosi", {31'd0, mosi}, 32'd0);
        checkOutput("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("abort_rsp_data", {24'd0, rsp_data}, 32'd0);
        checkOutput("abort_req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_ss_n", {31'd0, ss_n}, 32'd1);
        checkOutput("reset_mosi", {31'd0, mosi}, 32'd0);
        checkOutput("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("reset_rsp_data", {24'd0, rsp_data}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        gapThreeTest();

        applyStimulus(1'b0, 8'h3C, 8'hA5, 8'h00, 1'b0);
        waitIdle();
        applyStimulus(1'b1, 8'h3C, 8'h00, 8'hA5, 1'b0);
        waitIdle();

        applyStimulus(1'b0, 8'h00, 8'h5A, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'hFF, 8'hC3, 8'h00, 1'b0);
        waitIdle();
        applyStimulus(1'b1, 8'h00, 8'h00, 8'h5A, 1'b1);
        applyStimulus(1'b1, 8'hFF, 8'h00, 8'hC3, 1'b0);
        waitIdle();

        applyStimulus(1'b0, 8'h81, 8'h7E, 8'h00, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        req_rd    = 1'b1;
        req_addr  = 8'h55;
        req_wdata = 8'h11;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        waitIdle();
        applyStimulus(1'b1, 8'h81, 8'h00, 8'h7E, 1'b0);
        waitIdle();

        abortRead(8'h81);
        applyStimulus(1'b1, 8'h3C, 8'h00, 8'hA5, 1'b0);
        waitIdle();
        repeat (3) @(posedge clk);

        checkOutput("frames_left", frame_q.size(), 0);
        checkOutput("rsp_left", rsp_q.size(), 0);
        checkOutput("lat_left", lat_q.size(), 0);
        checkOutput("mosi_idle", {31'd0, idle_bad}, 32'd0);
        checkOutput("busy_vs_ready", {31'd0, busy_bad}, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
